led_blinker_multi: RTL and testbench



---
 rtl/led_blinker_multi.sv | 127 ++++++++++++
 tb/tb_led_blinker_multi.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/led_blinker_multi.sv
// Multi-channel LED blinker: shared tick prescaler, per-channel half-period from SW rate codes.
// Optional hold on SW[9] is compiled in with `define BLINKER_HOLD_EN.

module led_blinker_chan #(
    parameter int CW         = 4,
    parameter int BASE_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tick,
    input  logic [1:0] code,
    output logic       led
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          led_q, led_d;
    logic [31:0]   half_m1;

    always_comb begin
        half_m1 = (32'(BASE_TICKS) << code) - 32'd1;
        cnt_d   = cnt_q;
        led_d   = led_q;
        if (!en) begin
            cnt_d = '0;
            led_d = 1'b0;
        end else if (tick) begin
            // >= rather than == so a lowered rate past the current count toggles at once
            if (32'(cnt_q) >= half_m1) begin
                cnt_d = '0;
                led_d = ~led_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            led_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
        end
    end

    assign led = led_q;
endmodule

module led_blinker_multi #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int CHANNELS   = 4,
    parameter int BASE_TICKS = 125
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic [9:0]          SW,
    output logic [CHANNELS-1:0] LEDG
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int CW  = $clog2(8 * BASE_TICKS);

`ifdef BLINKER_HOLD_EN
    localparam int SW_N = 2 * CHANNELS + 2;
`else
    localparam int SW_N = 2 * CHANNELS + 1;
`endif

    logic [SW_N-1:0] sw_raw;
    logic [SW_N-1:0] sw_meta_q, sw_meta_d;
    logic [SW_N-1:0] sw_s_q, sw_s_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            en_s, hold_s, tick;
    logic            unused_sw;

    // Only rate, enable (and hold) bits get a synchroniser; the rest of SW is ignored
`ifdef BLINKER_HOLD_EN
    assign sw_raw = {SW[9], SW[8], SW[2*CHANNELS-1:0]};
    assign hold_s = sw_s_q[SW_N-1];
`else
    assign sw_raw = {SW[8], SW[2*CHANNELS-1:0]};
    assign hold_s = 1'b0;
`endif
    assign en_s      = sw_s_q[2*CHANNELS];
    assign unused_sw = ^SW;

    always_comb begin
        sw_meta_d = sw_raw;
        sw_s_d    = sw_meta_q;
        presc_d   = presc_q;
        if (!en_s) begin
            presc_d = '0;
        end else if (!hold_s) begin
            presc_d = (presc_q == PW'(DIV - 1)) ? '0 : presc_q + PW'(1);
        end
    end

    assign tick = en_s & ~hold_s & (presc_q == PW'(DIV - 1));

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sw_meta_q <= '0;
            sw_s_q    <= '0;
            presc_q   <= '0;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_s_q    <= sw_s_d;
            presc_q   <= presc_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        led_blinker_chan #(
            .CW         (CW),
            .BASE_TICKS (BASE_TICKS)
        ) u_chan (
            .clk  (CLOCK_50),
            .rst  (RESET),
            .en   (en_s),
            .tick (tick),
            .code (sw_s_q[2*c+1:2*c]),
            .led  (LEDG[c])
        );
    end
endmodule

// File: tb/tb_led_blinker_multi.sv
// Scoreboard bench for led_blinker_multi: stimulus pushes model LEDG per edge, monitor compares.
module tb_led_blinker_multi;
    localparam int DIV  = 4;
    localparam int BASE = 2;
    localparam int CH   = 4;
`ifdef BLINKER_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic          CLOCK_50 = 1'b0;
    logic          RESET    = 1'b1;
    logic [9:0]    SW       = '0;
    logic [CH-1:0] LEDG;

    int errors = 0;
    int checks = 0;
    logic [CH-1:0] exp_q[$];

    // Reference state: synchroniser copies, count of active edges, tick index of last toggle
    logic [9:0]    m_s1 = '0, m_s2 = '0;
    int            m_act = 0;
    int            m_last[CH];
    logic [CH-1:0] m_led = '0;

    led_blinker_multi #(
        .CLK_HZ     (40),
        .TICK_HZ    (10),
        .CHANNELS   (CH),
        .BASE_TICKS (BASE)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .SW       (SW),
        .LEDG     (LEDG)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_act = 0; m_led = '0;
        for (int c = 0; c < CH; c++) m_last[c] = 0;
    endtask

    task automatic model_edge();
        logic en, hold;
        int n, h;
        if (RESET) begin
            model_reset();
            return;
        end
        en   = m_s2[8];
        hold = HOLD & m_s2[9];
        if (!en) begin
            m_act = 0; m_led = '0;
            for (int c = 0; c < CH; c++) m_last[c] = 0;
        end else if (!hold) begin
            m_act++;
            if (m_act % DIV == 0) begin
                n = m_act / DIV;
                for (int c = 0; c < CH; c++) begin
                    h = BASE << m_s2[2*c +: 2];
                    if (n - m_last[c] >= h) begin
                        m_led[c]  = ~m_led[c];
                        m_last[c] = n;
                    end
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = SW;
    endtask

    task automatic step(input logic [9:0] v);
        SW = v;
        @(posedge CLOCK_50);
        model_edge();
        exp_q.push_back(m_led);
        #1;
    endtask

    task automatic run(input logic [9:0] v, input int n);
        repeat (n) step(v);
    endtask

    task automatic chk(input string nm, input logic [CH-1:0] got, input logic [CH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    initial begin : monitor
        logic [CH-1:0] e;
        forever begin
            @(negedge CLOCK_50);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ledg_scoreboard", LEDG, e);
            end
        end
    end

    initial begin : stim
        logic [9:0] r;
        logic [CH-1:0] want;
        model_reset();
        run(10'h000, 3);
        chk("reset_state", LEDG, '0);

        // Enable with codes 0..3; first rises land at timing edges 8/16/32/64 (+2 sync edges)
        RESET = 1'b0;
        for (int k = 1; k <= 140; k++) begin
            step(10'h1E4);
            want = 'x;
            case (k)
                9:   want = 4'b0000;
                10:  want = 4'b0001;
                18:  want = 4'b0010;
                34:  want = 4'b0100;
                65:  want = 4'b0111;
                66:  want = 4'b1000;
                129: want = 4'b1111;
                default: ;
            endcase
            if (k inside {9, 10, 18, 34, 65, 66, 129}) begin
                #1 chk($sformatf("first_rise_k%0d", k), LEDG, want);
            end
        end

        // Async reset mid-run
        #5 RESET = 1'b1;
        model_reset();
        #1 chk("async_reset", LEDG, '0);
        run(10'h1FF, 3);
        chk("reset_hold", LEDG, '0);
        RESET = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            step(10'h1FF);
            if (k == 65) #1 chk("all_code3_k65", LEDG, 4'b0000);
            if (k == 66) #1 chk("all_code3_k66", LEDG, 4'b1111);
        end

        // Rate lowered mid-count on ch0, then disable/re-enable
        run(10'h1E7, 30);
        run(10'h1E4, 50);
        run(10'h0E4, 10);
        chk("disabled", LEDG, '0);
        for (int k = 1; k <= 40; k++) begin
            step(10'h1E4);
            if (k == 9)  #1 chk("reen_k9",  {3'b0, LEDG[0]}, 4'b0000);
            if (k == 10) #1 chk("reen_k10", {3'b0, LEDG[0]}, 4'b0001);
        end

        // Hold pulse (ignored without the macro)
        run(10'h3E4, 50);
        run(10'h1E4, 100);

        for (int s = 0; s < 25; s++) begin
            r = 10'($urandom);
            r[8] = ($urandom_range(0, 7) != 0);
            r[9] = ($urandom_range(0, 3) == 0);
            run(r, $urandom_range(1, 150));
        end

        repeat (2) @(negedge CLOCK_50);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
